// File: rtl/glyph_pkg.sv
// Shared geometry, FSM state type and pROM address helper for the glyph pixel streamer.
package glyph_pkg;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int CODE_W  = 8;
  localparam int ROW_W   = $clog2(GLYPH_H);
  localparam int COL_W   = $clog2(GLYPH_W);
  localparam int ADDR_W  = CODE_W + ROW_W;
  localparam int COLOR_W = 16;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(GLYPH_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT
  } state_e;

  function automatic logic [ADDR_W-1:0] glyph_addr(input logic [CODE_W-1:0] code,
                                                   input logic [ROW_W-1:0]  row);
    return {code, row};
  endfunction
endpackage

// File: rtl/glyph_pixel_streamer_if.sv
// Pixel stream towards the SPI pixel writer: valid/ready plus row/glyph end markers.
interface glyph_pixel_streamer_if;
  import glyph_pkg::*;

  logic [COLOR_W-1:0] pix_data;
  logic               pix_valid;
  logic               pix_ready;
  logic               pix_row_end;
  logic               pix_last;

  modport master (output pix_data, pix_valid, pix_row_end, pix_last, input pix_ready);
  modport slave  (input pix_data, pix_valid, pix_row_end, pix_last, output pix_ready);
endinterface

// File: rtl/glyph_row_serializer.sv
// Turns one glyph row byte into GLYPH_W colour pixels, advancing only on handshake.
module glyph_row_serializer
  import glyph_pkg::*;
#(
  parameter bit MSB_LEFT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [GLYPH_W-1:0] i_din,
  input  logic [COLOR_W-1:0] i_fg,
  input  logic [COLOR_W-1:0] i_bg,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [COLOR_W-1:0] o_data,
  output logic               o_row_end
);
  logic [GLYPH_W-1:0] r_shift;
  logic [COL_W-1:0]   r_col;
  logic               r_valid;
  logic               w_fire;
  logic               w_at_end;
  logic               w_bit;

  assign w_fire   = r_valid && i_ready;
  assign w_at_end = (r_col == LAST_COL);
  assign w_bit    = MSB_LEFT ? r_shift[GLYPH_W-1] : r_shift[0];

  // The column counter parks on the last column; the row end is flagged, never wrapped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_din;
      r_col   <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      if (w_at_end) begin
        r_valid <= 1'b0;
      end else begin
        r_col   <= r_col + 1'b1;
        r_shift <= MSB_LEFT ? {r_shift[GLYPH_W-2:0], 1'b0} : {1'b0, r_shift[GLYPH_W-1:1]};
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_valid ? (w_bit ? i_fg : i_bg) : '0;
  assign o_row_end = r_valid && w_at_end;
endmodule

// File: rtl/glyph_pixel_streamer.sv
// Fetches the 16 rows of a glyph from the font pROM and streams them out as RGB565 pixels.
module glyph_pixel_streamer
  import glyph_pkg::*;
#(
  parameter bit MSB_LEFT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CODE_W-1:0]      char_code,
  input  logic [COLOR_W-1:0]     fg_color,
  input  logic [COLOR_W-1:0]     bg_color,
  input  logic                   char_valid,
  output logic                   char_ready,
  output logic                   rom_ce,
  output logic                   rom_oce,
  output logic                   rom_reset,
  output logic [ADDR_W-1:0]      rom_ad,
  input  logic [GLYPH_W-1:0]     rom_dout,
  glyph_pixel_streamer_if.master pix
);
  state_e             r_state, w_state_nxt;
  logic               r_phase, w_phase_nxt;
  logic [ROW_W-1:0]   r_row, w_row_nxt;
  logic [CODE_W-1:0]  r_code;
  logic [COLOR_W-1:0] r_fg, r_bg;
  logic [ADDR_W-1:0]  r_rom_ad, w_rom_ad_nxt;
  logic               w_accept;
  logic               w_load;
  logic               w_row_done;
  logic               w_pix_valid;
  logic               w_row_end;
  logic [COLOR_W-1:0] w_pix_data;

  assign char_ready = (r_state == IDLE);
  assign w_accept   = char_valid && char_ready;
  assign w_row_done = w_pix_valid && pix.pix_ready && w_row_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_phase  <= 1'b0;
      r_row    <= '0;
      r_code   <= '0;
      r_fg     <= '0;
      r_bg     <= '0;
      r_rom_ad <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_row    <= w_row_nxt;
      r_rom_ad <= w_rom_ad_nxt;
      if (w_accept) begin
        r_code <= char_code;
        r_fg   <= fg_color;
        r_bg   <= bg_color;
      end
    end
  end

  // The address register is loaded on entry to FETCH so it is already stable in phase 0.
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_row_nxt    = r_row;
    w_rom_ad_nxt = r_rom_ad;
    w_load       = 1'b0;
    rom_ce       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt  = FETCH;
          w_phase_nxt  = 1'b0;
          w_row_nxt    = '0;
          w_rom_ad_nxt = glyph_addr(char_code, {ROW_W{1'b0}});
        end
      end
      FETCH: begin
        if (!r_phase) begin
          rom_ce      = 1'b1;
          w_phase_nxt = 1'b1;
        end else begin
          w_load      = 1'b1;
          w_phase_nxt = 1'b0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_row_done) begin
          if (r_row == LAST_ROW) begin
            w_state_nxt = IDLE;
          end else begin
            w_row_nxt    = r_row + 1'b1;
            w_rom_ad_nxt = glyph_addr(r_code, r_row + 1'b1);
            w_state_nxt  = FETCH;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  glyph_row_serializer #(.MSB_LEFT(MSB_LEFT)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_din    (rom_dout),
    .i_fg     (r_fg),
    .i_bg     (r_bg),
    .i_ready  (pix.pix_ready),
    .o_valid  (w_pix_valid),
    .o_data   (w_pix_data),
    .o_row_end(w_row_end)
  );

  assign pix.pix_valid   = w_pix_valid;
  assign pix.pix_data    = w_pix_data;
  assign pix.pix_row_end = w_row_end;
  assign pix.pix_last    = w_row_end && (r_row == LAST_ROW);
  assign rom_oce         = rom_ce;
  assign rom_reset       = ~rst_n;
  assign rom_ad          = r_rom_ad;
endmodule
